transpose_buffer: RTL and testbench

TRANSPOSE_BUFFER -- requirements
Module: transpose_buffer

---
 rtl/transpose_buffer.sv | 102 ++++++++++
 tb/tb_transpose_buffer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/transpose_buffer.sv
// rtl/transpose_buffer.sv - 8x8 block transpose buffer, double-banked
// Rows arrive row-major into one bank while the other full bank drains column-major.
module transpose_buffer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_first,
  output logic         out_last
);

  logic [W-1:0] r_bank0 [64];
  logic [W-1:0] r_bank1 [64];
  logic [1:0]   r_full;
  logic         r_wr_bank;
  logic         r_rd_bank;
  logic [5:0]   r_wr_cnt;
  logic [5:0]   r_rd_cnt;
  logic         r_out_valid;
  logic         r_out_first;
  logic         r_out_last;
  logic [W-1:0] r_out_data;

  logic         w_wr_en;
  logic         w_wr_done;
  logic         w_load;
  logic         w_rd_done;
  logic [5:0]   w_rd_addr;
  logic [W-1:0] w_rd_data;
  logic [1:0]   w_full_set;
  logic [1:0]   w_full_clr;

  assign in_ready  = !r_full[r_wr_bank];
  assign w_wr_en   = in_valid && in_ready;
  assign w_wr_done = w_wr_en && (r_wr_cnt == 6'd63);
  assign w_load    = r_full[r_rd_bank] && (!r_out_valid || out_ready);
  assign w_rd_done = w_load && (r_rd_cnt == 6'd63);

  // Storage is row-major {row,col}; the read counter walks rows fastest, so its fields swap.
  assign w_rd_addr = {r_rd_cnt[2:0], r_rd_cnt[5:3]};
  assign w_rd_data = r_rd_bank ? r_bank1[w_rd_addr] : r_bank0[w_rd_addr];

  assign w_full_set = w_wr_done ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign w_full_clr = w_rd_done ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      if (r_wr_bank) r_bank1[r_wr_cnt] <= in_data;
      else           r_bank0[r_wr_cnt] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_cnt  <= 6'd0;
      r_rd_cnt  <= 6'd0;
    end else begin
      r_full <= (r_full | w_full_set) & ~w_full_clr;
      if (w_wr_en) begin
        r_wr_cnt <= r_wr_cnt + 6'd1;
        if (w_wr_done) r_wr_bank <= !r_wr_bank;
      end
      if (w_load) begin
        r_rd_cnt <= r_rd_cnt + 6'd1;
        if (w_rd_done) r_rd_bank <= !r_rd_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else if (w_load) begin
      r_out_data  <= w_rd_data;
      r_out_valid <= 1'b1;
      r_out_first <= (r_rd_cnt == 6'd0);
      r_out_last  <= (r_rd_cnt == 6'd63);
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_first = r_out_first;
  assign out_last  = r_out_last;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_transpose_buffer.sv
// tb/tb_transpose_buffer.sv - self-checking bench for transpose_buffer
// Reference: collected 64-sample blocks are transposed into an expected output queue.
module tb_transpose_buffer;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_first;
  logic         out_last;

  transpose_buffer #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_first(out_first), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic         f;
    logic         l;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] blk[64];
  int           blk_n = 0;
  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  int           blk_done_cyc = 0;
  int           rise_cyc = -1;
  int           ov_run = 0;
  int           ov_run_max = 0;
  int           in_stall = 0;
  bit           rand_rdy = 1'b0;
  bit           prev_ov = 1'b0;
  bit           stalled = 1'b0;
  logic [W-1:0] held_d;
  logic         held_f;
  logic         held_l;
  bit           s_hs;
  bit           s_last;
  bit           s_in_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    blk_n   = 0;
    stalled = 1'b0;
    prev_ov = 1'b0;
  endtask

  // One clock: observe at the negedge (inputs/outputs as seen by the next rising edge).
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    s_hs       = 1'b0;
    s_last     = 1'b0;
    s_in_ready = in_ready;
    if (!rst) begin
      s_hs   = in_valid && in_ready;
      s_last = out_valid && out_last;
      if (in_valid && !in_ready) in_stall++;
      if (s_hs) begin
        blk[blk_n] = in_data;
        blk_n++;
        if (blk_n == 64) begin
          for (int c = 0; c < 8; c++)
            for (int r = 0; r < 8; r++)
              exp_q.push_back('{d: blk[r*8+c], f: (r == 0 && c == 0), l: (r == 7 && c == 7)});
          blk_n = 0;
          blk_done_cyc = cyc;
        end
      end
      if (stalled) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(held_d));
        check("hold_first", 32'(out_first), 32'(held_f));
        check("hold_last", 32'(out_last), 32'(held_l));
      end
      if (out_valid) begin
        if (!prev_ov) rise_cyc = cyc;
        ov_run++;
        if (ov_run > ov_run_max) ov_run_max = ov_run;
      end else begin
        ov_run = 0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e.d));
          check("out_first", 32'(out_first), 32'(e.f));
          check("out_last", 32'(out_last), 32'(e.l));
        end
      end
      stalled = out_valid && !out_ready;
      held_d  = out_data;
      held_f  = out_first;
      held_l  = out_last;
      prev_ov = out_valid;
    end
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [W-1:0] v);
    int k = 0;
    in_data  = v;
    in_valid = 1'b1;
    do begin
      tick();
      k++;
    end while (!s_hs && k < 1000);
    if (!s_hs) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < budget) begin
      tick();
      k++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_idle", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int k;
    int early;

    // Reset state
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_first", 32'(out_first), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Single block 0..63 with latency
    out_ready = 1'b1;
    rise_cyc = -1;
    for (int i = 0; i < 64; i++) send(W'(i));
    in_valid = 1'b0;
    drain(300);
    check("latency_single", 32'(rise_cyc - blk_done_cyc), 32'd2);

    // Streaming 3 blocks back-to-back
    in_stall = 0; ov_run = 0; ov_run_max = 0;
    for (int i = 0; i < 192; i++) send(W'(i));
    in_valid = 1'b0;
    drain(400);
    check("stream_in_stall", 32'(in_stall), 32'd0);
    check("stream_ov_run", 32'(ov_run_max), 32'd192);

    // Backpressure: two full banks
    out_ready = 1'b0;
    for (int i = 0; i < 128; i++) send(W'($urandom_range(0, (1 << W) - 1)));
    in_valid = 1'b0;
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    early = 0;
    repeat (5) begin
      tick();
      if (s_in_ready) early++;
    end
    out_ready = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
      if (!s_last && s_in_ready) early++;
    end while (!s_last && k < 200);
    check("bp_ready_at_last", 32'(s_in_ready), 32'd1);
    check("bp_no_early_ready", 32'(early), 32'd0);
    drain(400);

    // Random out_ready and input gaps over 10 blocks
    rand_rdy = 1'b1;
    for (int i = 0; i < 640; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      send(W'($urandom_range(0, (1 << W) - 1)));
    end
    in_valid = 1'b0;
    drain(4000);
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    drain(200);

    // Reset mid-drain and mid-block, then a clean block
    for (int i = 0; i < 64; i++) send(W'(i + 100));
    for (int i = 0; i < 30; i++) send(W'(i + 500));
    in_valid = 1'b0;
    check("pre_rst_busy", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_last", 32'(out_last), 32'd0);
    rise_cyc = -1;
    for (int i = 0; i < 64; i++) send(W'(i));
    in_valid = 1'b0;
    drain(300);
    check("latency_after_rst", 32'(rise_cyc - blk_done_cyc), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
